// File: rtl/mode_sel_pkg.sv
// Shared defaults and width helper for the push-button mode selector.
package mode_sel_pkg;

    localparam int NUM_MODES_DEF         = 4;
    localparam int DEBOUNCE_CYCLES_DEF   = 500000;
    localparam int LONG_PRESS_CYCLES_DEF = 50000000;

    // Never returns 0, so a 2-entry range still gets a 1-bit field.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/mode_selector_btn_debounce.sv
// One raw active-low button: 2-FF synchroniser, stability counter and
// edge pulses on the debounced level.
module btn_debounce
    import mode_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int               CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= raw_n;
            sync_q2 <= sync_q1;
        end
    end

    // Any return to the accepted level restarts the stability window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync_q2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_q2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) level_d <= 1'b1;
        else        level_d <= level;
    end

    assign press_pulse   = level_d & ~level;
    assign release_pulse = ~level_d & level;

endmodule

// File: rtl/mode_selector.sv
// Next/prev push-button mode selector with wrap-around and a long press on
// next that returns to mode 0.
module mode_selector
    import mode_sel_pkg::*;
#(
    parameter int NUM_MODES         = NUM_MODES_DEF,
    parameter int MODE_W            = clog2_min1(NUM_MODES),
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next_n,
    input  logic              btn_prev_n,
    output logic [MODE_W-1:0] mode,
    output logic              mode_changed,
    output logic              long_press
);

    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
    localparam int                HOLD_W    = clog2_min1(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    logic              next_level, next_press, next_release;
    logic              prev_level, prev_press, prev_release;
    logic              unused_prev;
    logic [HOLD_W-1:0] hold_cnt;
    logic              lp_hit;
    logic [MODE_W-1:0] mode_nx;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk           (clk),
        .reset         (reset),
        .raw_n         (btn_next_n),
        .level         (next_level),
        .press_pulse   (next_press),
        .release_pulse (next_release)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk           (clk),
        .reset         (reset),
        .raw_n         (btn_prev_n),
        .level         (prev_level),
        .press_pulse   (prev_press),
        .release_pulse (prev_release)
    );

    assign unused_prev = prev_level ^ prev_release;

    // Saturating hold counter: one long press per hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (next_level || next_release || prev_press) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign lp_hit = !next_level && !prev_press && (hold_cnt == HOLD_LAST);

    always_comb begin
        mode_nx = mode;
        if (lp_hit) begin
            mode_nx = '0;
        end else if (next_press && !prev_press) begin
            mode_nx = (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
        end else if (prev_press && !next_press) begin
            mode_nx = (mode == '0) ? MODE_LAST : mode - MODE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode         <= '0;
            mode_changed <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            mode         <= mode_nx;
            mode_changed <= (mode_nx != mode);
            long_press   <= lp_hit;
        end
    end

endmodule

// File: tb/tb_mode_selector.sv
// Scoreboard bench for mode_selector with NUM_MODES=3, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20.
module tb_mode_selector;

    localparam int LAT = 7;
    localparam int LP  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_next_n = 1'b1;
    logic       btn_prev_n = 1'b1;
    logic [1:0] mode;
    logic       mode_changed;
    logic       long_press;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         at;
        logic [1:0] mode;
        logic       mc;
        logic       lp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mode_selector #(
        .NUM_MODES         (3),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_next_n   (btn_next_n),
        .btn_prev_n   (btn_prev_n),
        .mode         (mode),
        .mode_changed (mode_changed),
        .long_press   (long_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every output pulse must match the next expected event, including its cycle.
    always @(negedge clk) begin
        if (reset && (mode_changed || long_press)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: cyc=%0d mode=%0d mc=%0b lp=%0b, required no event",
                         cyc, mode, mode_changed, long_press);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.at != cyc || mon_e.mode !== mode ||
                    mon_e.mc !== mode_changed || mon_e.lp !== long_press) begin
                    bad++;
                    $display("FAIL sb_event: got cyc=%0d mode=%0d mc=%0b lp=%0b, required cyc=%0d mode=%0d mc=%0b lp=%0b",
                             cyc, mode, mode_changed, long_press,
                             mon_e.at, mon_e.mode, mon_e.mc, mon_e.lp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input int at, input logic [1:0] m, input logic mc, input logic lp);
        exp_t e;
        e.at = at; e.mode = m; e.mc = mc; e.lp = lp;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 = next, 1 = prev. Pushes the expected mode step.
    task automatic press(input bit which, input int hold, input logic [1:0] m_exp);
        @(negedge clk);
        if (which) btn_prev_n = 1'b0;
        else       btn_next_n = 1'b0;
        expect_ev(cyc + LAT, m_exp, 1'b1, 1'b0);
        wait_cyc(hold);
        btn_next_n = 1'b1;
        btn_prev_n = 1'b1;
        wait_cyc(12);
    endtask

    int c0;

    initial begin
        wait_cyc(3);
        check("reset_mode", mode, 0);
        check("reset_mc", mode_changed, 0);
        check("reset_lp", long_press, 0);
        reset = 1'b1;
        wait_cyc(3);

        press(0, 10, 2'd1);
        press(0, 10, 2'd2);
        press(0, 10, 2'd0);

        press(1, 10, 2'd2);
        press(1, 10, 2'd1);

        // Bouncing contact: only the final settled low is accepted.
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn_next_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_cyc(2);
        end
        btn_next_n = 1'b0;
        expect_ev(cyc + LAT, 2'd2, 1'b1, 1'b0);
        wait_cyc(10);
        btn_next_n = 1'b1;
        wait_cyc(12);

        btn_next_n = 1'b0;
        wait_cyc(3);
        btn_next_n = 1'b1;
        wait_cyc(12);
        check("glitch_mode", mode, 2);

        btn_next_n = 1'b0;
        btn_prev_n = 1'b0;
        wait_cyc(10);
        btn_next_n = 1'b1;
        btn_prev_n = 1'b1;
        wait_cyc(12);
        check("both_mode", mode, 2);

        press(1, 10, 2'd1);

        // Long press: step to 2 at press, back to 0 with long_press 19 cycles later.
        @(negedge clk);
        btn_next_n = 1'b0;
        c0 = cyc;
        expect_ev(c0 + LAT, 2'd2, 1'b1, 1'b0);
        expect_ev(c0 + LAT - 1 + LP, 2'd0, 1'b1, 1'b1);
        wait_cyc(LAT - 1 + LP + 100);
        check("lp_hold_mode", mode, 0);
        btn_next_n = 1'b1;
        wait_cyc(12);

        press(0, 10, 2'd1);
        @(negedge clk);
        btn_next_n = 1'b0;
        expect_ev(cyc + LAT, 2'd2, 1'b1, 1'b0);
        wait_cyc(10);
        check("pre_reset_mode", mode, 2);
        reset = 1'b0;
        #1;
        check("midreset_mode", mode, 0);
        check("midreset_mc", mode_changed, 0);
        wait_cyc(3);
        reset = 1'b1;
        expect_ev(cyc + LAT, 2'd1, 1'b1, 1'b0);
        wait_cyc(10);
        btn_next_n = 1'b1;
        wait_cyc(12);
        check("final_mode", mode, 1);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
